batch_rr_arbiter: RTL and testbench

BATCH_RR_ARBITER -- requirements
Module: batch_rr_arbiter

---
 rtl/batch_rr_arbiter.sv | 78 +++++++
 tb/tb_batch_rr_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/batch_rr_arbiter.sv
// batch_rr_arbiter: batch-snapshot arbiter with fixed-priority or round-robin selection.
// A batch is frozen from request and drained one registered grant per accepted cycle.
module batch_rr_arbiter #(
   parameter int N   = 8,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset_b,
   input  logic [N-1:0]   request,
   input  logic           mode,
   input  logic           ready,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic           stall,
   output logic           batch_done
);
   logic [N-1:0]   r_req;
   logic [N-1:0]   r_grant;
   logic [IDW-1:0] r_ptr;
   logic           w_sel;
   logic           w_any;
   logic [N-1:0]   w_qual;
   logic [N-1:0]   w_hi;
   logic [N-1:0]   w_pick;
   logic [N-1:0]   w_onehot;
   logic [IDW-1:0] w_base;
   logic [IDW-1:0] w_win;
   logic [IDW-1:0] w_ptr_nxt;
   logic [IDW-1:0] w_id;

   assign stall       = |r_req;
   assign grant       = r_grant;
   assign grant_valid = |r_grant;
   assign grant_id    = w_id;
   assign batch_done  = grant_valid & ready & ~stall;
   assign w_sel       = ~grant_valid | ready;
   assign w_qual      = stall ? r_req : request;
   assign w_any       = |w_qual;
   assign w_base      = mode ? r_ptr : '0;

   // Round-robin: prefer the lowest candidate at or above the base, else wrap to the lowest overall.
   always_comb begin
      w_hi = '0;
      for (int i = 0; i < N; i++) w_hi[i] = w_qual[i] && (IDW'(i) >= w_base);
   end

   assign w_pick = (|w_hi) ? w_hi : w_qual;

   always_comb begin
      w_win = '0;
      for (int i = N - 1; i >= 0; i--) if (w_pick[i]) w_win = IDW'(i);
   end

   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < N; i++) w_onehot[i] = w_any && (w_win == IDW'(i));
   end

   assign w_ptr_nxt = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);

   always_comb begin
      w_id = '0;
      for (int i = 0; i < N; i++) if (r_grant[i]) w_id = w_id | IDW'(i);
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_req   <= '0;
         r_grant <= '0;
         r_ptr   <= '0;
      end else if (w_sel) begin
         r_grant <= w_onehot;
         r_req   <= w_qual & ~w_onehot;
         if (w_any) r_ptr <= w_ptr_nxt;
      end
   end
endmodule

// File: tb/tb_batch_rr_arbiter.sv
// tb_batch_rr_arbiter: vector table, directed corner sequences and a randomized run
// against a queue-free behavioural model of the batch arbiter (N=8, plus N=3 and N=1 builds).
module tb_batch_rr_arbiter;
   logic       clk = 1'b0;
   logic       reset_b = 1'b0;
   logic [7:0] request = '0;
   logic       mode = 1'b0;
   logic       ready = 1'b1;
   logic [2:0] req3 = '0;
   logic [0:0] req1 = '0;
   logic [7:0] g8;
   logic       gv8, st8, bd8;
   logic [2:0] id8;
   logic [2:0] g3;
   logic       gv3, st3, bd3;
   logic [1:0] id3;
   logic [0:0] g1;
   logic       gv1, st1, bd1;
   logic [0:0] id1;
   int checks = 0;
   int errors = 0;

   logic [7:0] m_pend;
   int         m_gid;
   int         m_ptr;

   typedef struct {
      logic [7:0] req;
      logic       md;
      logic       rdy;
      logic [7:0] g;
      logic       st;
      logic       bd;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   batch_rr_arbiter #(.N(8)) dut (
      .clk(clk), .reset_b(reset_b), .request(request), .mode(mode), .ready(ready),
      .grant(g8), .grant_valid(gv8), .grant_id(id8), .stall(st8), .batch_done(bd8)
   );
   batch_rr_arbiter #(.N(3)) u3 (
      .clk(clk), .reset_b(reset_b), .request(req3), .mode(mode), .ready(ready),
      .grant(g3), .grant_valid(gv3), .grant_id(id3), .stall(st3), .batch_done(bd3)
   );
   batch_rr_arbiter #(.N(1)) u1 (
      .clk(clk), .reset_b(reset_b), .request(req1), .mode(mode), .ready(ready),
      .grant(g1), .grant_valid(gv1), .grant_id(id1), .stall(st1), .batch_done(bd1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [7:0] g);
      int r = 0;
      for (int i = 0; i < 8; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic check8(input string tag, input logic [7:0] g, input logic st, input logic bd);
      check({tag, ".grant"}, 32'(g8), 32'(g));
      check({tag, ".grant_valid"}, 32'(gv8), 32'(g != 0));
      check({tag, ".grant_id"}, 32'(id8), 32'(idx_of(g)));
      check({tag, ".stall"}, 32'(st8), 32'(st));
      check({tag, ".batch_done"}, 32'(bd8), 32'(bd));
   endtask

   task automatic add(input logic [7:0] rq, input logic md, input logic rd,
                      input logic [7:0] g, input logic st, input logic bd);
      vec_t v;
      v.req = rq; v.md = md; v.rdy = rd; v.g = g; v.st = st; v.bd = bd;
      tbl.push_back(v);
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_gid  = -1;
      m_ptr  = 0;
   endtask

   // Model of one clock edge: pick from the frozen batch if any, else from live requests.
   task automatic model_step(input logic [7:0] rq, input logic md, input logic rd);
      logic [7:0] q;
      int base, w;
      if (m_gid >= 0 && !rd) return;
      q = (m_pend != 0) ? m_pend : rq;
      base = md ? m_ptr : 0;
      w = -1;
      for (int k = 0; k < 8; k++) if (w < 0 && q[(base + k) % 8]) w = (base + k) % 8;
      if (w >= 0) begin
         q[w] = 1'b0;
         m_ptr = (w + 1) % 8;
      end
      m_gid = w;
      m_pend = q;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      request = 8'hFF; req3 = 3'b111; req1 = 1'b1;
      tick(); tick();
      check8("reset", 8'h00, 1'b0, 1'b0);
      check("reset.g3", 32'(g3), 0);
      check("reset.g1", 32'(g1), 0);

      add(8'hA6, 0, 1, 8'h02, 1, 0); add(8'hA6, 0, 1, 8'h04, 1, 0);
      add(8'hA6, 0, 1, 8'h20, 1, 0); add(8'hA6, 0, 1, 8'h80, 0, 1);
      add(8'h00, 0, 1, 8'h00, 0, 0);
      add(8'h03, 0, 1, 8'h01, 1, 0); add(8'h83, 0, 1, 8'h02, 0, 1);
      add(8'h83, 0, 1, 8'h01, 1, 0); add(8'h83, 0, 1, 8'h02, 1, 0);
      add(8'h83, 0, 1, 8'h80, 0, 1); add(8'h00, 0, 1, 8'h00, 0, 0);
      add(8'h34, 0, 1, 8'h04, 1, 0); add(8'hFF, 0, 0, 8'h04, 1, 0);
      add(8'hFF, 0, 0, 8'h04, 1, 0); add(8'hFF, 0, 0, 8'h04, 1, 0);
      add(8'h34, 0, 1, 8'h10, 1, 0); add(8'h00, 0, 1, 8'h20, 0, 1);
      add(8'h00, 0, 1, 8'h00, 0, 0);
      add(8'h10, 1, 1, 8'h10, 0, 1); add(8'h21, 1, 1, 8'h20, 1, 0);
      add(8'h21, 1, 1, 8'h01, 0, 1); add(8'h00, 0, 1, 8'h00, 0, 0);
      add(8'h21, 0, 1, 8'h01, 1, 0); add(8'h21, 0, 1, 8'h20, 0, 1);
      add(8'h00, 0, 1, 8'h00, 0, 0);

      request = tbl[0].req; mode = tbl[0].md; ready = tbl[0].rdy;
      reset_b = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         request = tbl[i].req; mode = tbl[i].md; ready = tbl[i].rdy;
         tick();
         check8($sformatf("vec%0d", i), tbl[i].g, tbl[i].st, tbl[i].bd);
      end

      request = 8'hFF; mode = 1'b0; ready = 1'b1;
      tick();
      check8("prereset", 8'h01, 1'b1, 1'b0);
      #2 reset_b = 1'b0;
      #1 check8("async_reset", 8'h00, 1'b0, 1'b0);
      tick();
      reset_b = 1'b1; request = 8'h05; mode = 1'b1;
      tick();
      check8("post_reset1", 8'h01, 1'b1, 1'b0);
      tick();
      check8("post_reset2", 8'h04, 1'b0, 1'b1);

      reset_b = 1'b0; request = 8'h00;
      tick();
      reset_b = 1'b1; mode = 1'b1; ready = 1'b1; req3 = 3'b111; req1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [2:0] eg;
         eg = 3'b001 << (i % 3);
         tick();
         check($sformatf("n3.grant%0d", i), 32'(g3), 32'(eg));
         check($sformatf("n3.id%0d", i), 32'(id3), 32'(i % 3));
         check($sformatf("n3.stall%0d", i), 32'(st3), 32'((i % 3) != 2));
         check($sformatf("n1.grant%0d", i), 32'(g1), 1);
         check($sformatf("n1.id%0d", i), 32'(id1), 0);
         check($sformatf("n1.stall%0d", i), 32'(st1), 0);
      end

      reset_b = 1'b0;
      tick();
      reset_b = 1'b1;
      model_reset();
      for (int c = 0; c < 600; c++) begin
         logic [7:0] eg;
         request = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         ready = ($urandom_range(0, 9) < 7);
         model_step(request, mode, ready);
         tick();
         eg = (m_gid >= 0) ? (8'h01 << m_gid) : 8'h00;
         check8($sformatf("rand%0d", c), eg, m_pend != 0, (m_gid >= 0) && ready && (m_pend == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
